// File: rtl/hwpe_ctrl_uloop_seq.sv
// -----------------------------------------------------------------------------
// hwpe_ctrl_uloop_seq
//
// Initiator side of the uloop control interface. Each uloop step becomes one
// streamer address request (per-lane base plus uloop offset) with a
// valid/ready handshake. Accepted requests are counted and job completion is
// pulsed on done_o.
//
// The shared uloop types live in hwpe_ctrl_package, kept in this file so the
// block is self-contained.
//
// Ports:
//   clk_i, rst_ni       clock, asynchronous active-low reset
//   test_mode_i         test mode, no functional effect
//   clear_i             synchronous soft clear, overrides every state
//   start_i             job start pulse, honoured only in IDLE
//   base_addr_i         per-lane base addresses, sampled on accepted start
//   ctrl_uloop_o        uloop control (enable / clear / ready)
//   flags_uloop_i       uloop flags (valid / done / offs / idx_update / loop)
//   req_valid_o/ready_i request handshake
//   req_addr_o          per-lane request addresses
//   req_loop_o          loop level of the step that produced the request
//   req_idx_update_o    idx_update vector of that step
//   req_last_o          final request of the job
//   iter_cnt_o          requests accepted in the current job
//   busy_o              high outside IDLE
//   done_o              one-cycle completion pulse
//
// state  | meaning
// IDLE   | waiting for start_i
// CLR    | one cycle of uloop clear before the first request
// ISSUE  | request pending on the streamer port, uloop stalled
// RUN    | uloop enabled, waiting for the next step or done
// FINISH | one-cycle done_o pulse
// -----------------------------------------------------------------------------
package hwpe_ctrl_package;
    localparam int unsigned ULOOP_MAX_NB_LOOPS  = 6;
    localparam int unsigned ULOOP_MAX_NB_REG    = 5;
    localparam int unsigned ULOOP_MAX_REG_WIDTH = 32;
    localparam int unsigned ULOOP_MAX_LOOP_W    = $clog2(ULOOP_MAX_NB_LOOPS);

    typedef struct packed {
        logic enable;
        logic clear;
        logic ready;
    } ctrl_uloop_t;

    typedef struct packed {
        logic                                                       valid;
        logic                                                       done;
        logic [ULOOP_MAX_NB_REG-1:0][ULOOP_MAX_REG_WIDTH-1:0]      offs;
        logic [ULOOP_MAX_NB_LOOPS-1:0]                              idx_update;
        logic [ULOOP_MAX_LOOP_W-1:0]                                loop;
    } flags_uloop_t;
endpackage

module hwpe_ctrl_uloop_seq
    import hwpe_ctrl_package::*;
#(
    parameter int unsigned NB_REG     = ULOOP_MAX_NB_REG,
    parameter int unsigned REG_WIDTH  = ULOOP_MAX_REG_WIDTH,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned NB_LOOPS   = ULOOP_MAX_NB_LOOPS,
    parameter int unsigned ITER_WIDTH = 16,
    localparam int unsigned LOOP_W    = (NB_LOOPS > 1) ? $clog2(NB_LOOPS) : 1
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic                              test_mode_i,
    input  logic                              clear_i,
    input  logic                              start_i,
    input  logic [NB_REG-1:0][ADDR_WIDTH-1:0] base_addr_i,
    output ctrl_uloop_t                       ctrl_uloop_o,
    input  flags_uloop_t                      flags_uloop_i,
    output logic                              req_valid_o,
    input  logic                              req_ready_i,
    output logic [NB_REG-1:0][ADDR_WIDTH-1:0] req_addr_o,
    output logic [LOOP_W-1:0]                 req_loop_o,
    output logic [NB_LOOPS-1:0]               req_idx_update_o,
    output logic                              req_last_o,
    output logic [ITER_WIDTH-1:0]             iter_cnt_o,
    output logic                              busy_o,
    output logic                              done_o
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CLR    = 3'd1,
        ISSUE  = 3'd2,
        RUN    = 3'd3,
        FINISH = 3'd4
    } state_t;

    state_t                            state_q;
    logic [NB_REG-1:0][ADDR_WIDTH-1:0] base_q;
    logic [NB_REG-1:0][REG_WIDTH-1:0]  offs_q;
    logic [LOOP_W-1:0]                 loop_q;
    logic [NB_LOOPS-1:0]               idx_update_q;
    logic                              last_q;
    logic [ITER_WIDTH-1:0]             iter_q;

    logic unused_test_mode;
    assign unused_test_mode = test_mode_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            base_q       <= '0;
            offs_q       <= '0;
            loop_q       <= '0;
            idx_update_q <= '0;
            last_q       <= 1'b0;
            iter_q       <= '0;
        end else if (clear_i) begin
            state_q      <= IDLE;
            base_q       <= '0;
            offs_q       <= '0;
            loop_q       <= '0;
            idx_update_q <= '0;
            last_q       <= 1'b0;
            iter_q       <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        base_q       <= base_addr_i;
                        offs_q       <= '0;
                        loop_q       <= '0;
                        idx_update_q <= '0;
                        last_q       <= 1'b0;
                        iter_q       <= '0;
                        state_q      <= CLR;
                    end
                end
                CLR: state_q <= ISSUE;
                ISSUE: begin
                    if (req_ready_i) begin
                        iter_q  <= iter_q + ITER_WIDTH'(1);
                        state_q <= last_q ? FINISH : RUN;
                    end
                end
                RUN: begin
                    // A step carrying done still needs its own request, so
                    // valid wins over done.
                    if (flags_uloop_i.valid) begin
                        for (int i = 0; i < NB_REG; i++) begin
                            offs_q[i] <= flags_uloop_i.offs[i][REG_WIDTH-1:0];
                        end
                        loop_q       <= flags_uloop_i.loop[LOOP_W-1:0];
                        idx_update_q <= flags_uloop_i.idx_update[NB_LOOPS-1:0];
                        last_q       <= flags_uloop_i.done;
                        state_q      <= ISSUE;
                    end else if (flags_uloop_i.done) begin
                        state_q <= FINISH;
                    end
                end
                FINISH:  state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // State decodes; only the clear_i path is combinational.
    logic issue;
    assign issue = (state_q == ISSUE) && !clear_i;

    assign ctrl_uloop_o.enable = (state_q == RUN) && !clear_i;
    assign ctrl_uloop_o.ready  = (state_q == RUN) && !clear_i;
    assign ctrl_uloop_o.clear  = (state_q == CLR) || clear_i;

    assign req_valid_o      = issue;
    assign req_loop_o       = issue ? loop_q : '0;
    assign req_idx_update_o = issue ? idx_update_q : '0;
    assign req_last_o       = issue && last_q;
    assign iter_cnt_o       = iter_q;
    assign busy_o           = (state_q != IDLE);
    assign done_o           = (state_q == FINISH) && !clear_i;

    always_comb begin
        req_addr_o = '0;
        if (issue) begin
            for (int i = 0; i < NB_REG; i++) begin
                req_addr_o[i] = base_q[i] + ADDR_WIDTH'(offs_q[i]);
            end
        end
    end

endmodule

// File: tb/tb_hwpe_ctrl_uloop_seq.sv
module tb_hwpe_ctrl_uloop_seq;
    import hwpe_ctrl_package::*;

    localparam int NB_REG   = ULOOP_MAX_NB_REG;
    localparam int NB_LOOPS = ULOOP_MAX_NB_LOOPS;
    localparam int LOOP_W   = $clog2(NB_LOOPS);

    logic                      clk_i = 1'b0;
    logic                      rst_ni = 1'b0;
    logic                      test_mode_i = 1'b0;
    logic                      clear_i = 1'b0;
    logic                      start_i = 1'b0;
    logic [NB_REG-1:0][31:0]   base_addr = '0;
    ctrl_uloop_t               ctrl_uloop;
    flags_uloop_t              flags = '0;
    logic                      req_valid;
    logic                      req_ready = 1'b0;
    logic [NB_REG-1:0][31:0]   req_addr;
    logic [LOOP_W-1:0]         req_loop;
    logic [NB_LOOPS-1:0]       req_idx_update;
    logic                      req_last;
    logic [15:0]               iter_cnt;
    logic                      busy;
    logic                      done;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk_i = ~clk_i;

    hwpe_ctrl_uloop_seq dut (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .test_mode_i      (test_mode_i),
        .clear_i          (clear_i),
        .start_i          (start_i),
        .base_addr_i      (base_addr),
        .ctrl_uloop_o     (ctrl_uloop),
        .flags_uloop_i    (flags),
        .req_valid_o      (req_valid),
        .req_ready_i      (req_ready),
        .req_addr_o       (req_addr),
        .req_loop_o       (req_loop),
        .req_idx_update_o (req_idx_update),
        .req_last_o       (req_last),
        .iter_cnt_o       (iter_cnt),
        .busy_o           (busy),
        .done_o           (done)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_en"},    ctrl_uloop.enable, 1'b0);
        check({tag, "_clr"},   ctrl_uloop.clear, 1'b0);
        check({tag, "_rdy"},   ctrl_uloop.ready, 1'b0);
        check({tag, "_valid"}, req_valid, 1'b0);
        check({tag, "_addr"},  req_addr[0], 32'h0);
        check({tag, "_last"},  req_last, 1'b0);
        check({tag, "_iter"},  iter_cnt, 16'd0);
        check({tag, "_busy"},  busy, 1'b0);
        check({tag, "_done"},  done, 1'b0);
    endtask

    // Start pulse, pass through CLR; returns with the FSM in ISSUE.
    task automatic start_job(input logic [31:0] b0, input logic [31:0] b1);
        base_addr[0] = b0;
        base_addr[1] = b1;
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        base_addr = '0;
        step();
    endtask

    // One uloop step presented for a single cycle while in RUN.
    task automatic uloop_step(input logic [31:0] o0, input logic [31:0] o1,
                              input logic [LOOP_W-1:0] lp, input logic [NB_LOOPS-1:0] idx,
                              input logic vld, input logic dn);
        flags.offs[0]     = o0;
        flags.offs[1]     = o1;
        flags.loop        = lp;
        flags.idx_update  = idx;
        flags.valid       = vld;
        flags.done        = dn;
        step();
        flags = '0;
    endtask

    initial begin
        // Reset state
        #12;
        check_quiet("rst");
        rst_ni = 1'b1;
        step();

        // Basic job: offsets 0x10, 0x20 (done with the last valid)
        req_ready = 1'b1;
        base_addr[0] = 32'h1000;
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        check("clr_clear", ctrl_uloop.clear, 1'b1);
        check("clr_enable", ctrl_uloop.enable, 1'b0);
        check("clr_busy", busy, 1'b1);
        check("clr_valid", req_valid, 1'b0);
        step();
        check("req0_valid", req_valid, 1'b1);
        check("req0_addr", req_addr[0], 32'h1000);
        check("req0_last", req_last, 1'b0);
        check("req0_en", ctrl_uloop.enable, 1'b0);
        step();
        check("run0_iter", iter_cnt, 16'd1);
        check("run0_en", ctrl_uloop.enable, 1'b1);
        check("run0_rdy", ctrl_uloop.ready, 1'b1);
        check("run0_valid", req_valid, 1'b0);
        uloop_step(32'h10, 32'h0, 3'd1, 6'h03, 1'b1, 1'b0);
        check("req1_addr", req_addr[0], 32'h1010);
        check("req1_loop", req_loop, 3'd1);
        check("req1_idx", req_idx_update, 6'h03);
        check("req1_last", req_last, 1'b0);
        step();
        check("run1_iter", iter_cnt, 16'd2);
        uloop_step(32'h20, 32'h0, 3'd2, 6'h07, 1'b1, 1'b1);
        check("req2_addr", req_addr[0], 32'h1020);
        check("req2_loop", req_loop, 3'd2);
        check("req2_last", req_last, 1'b1);
        step();
        check("fin_done", done, 1'b1);
        check("fin_iter", iter_cnt, 16'd3);
        check("fin_valid", req_valid, 1'b0);
        step();
        check("idle_done", done, 1'b0);
        check("idle_busy", busy, 1'b0);
        check("idle_iter_hold", iter_cnt, 16'd3);

        // Backpressure on the second request
        start_job(32'h1000, 32'h0);
        step();
        uloop_step(32'h40, 32'h0, 3'd0, 6'h01, 1'b1, 1'b0);
        req_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            check("bp_valid", req_valid, 1'b1);
            check("bp_addr", req_addr[0], 32'h1040);
            check("bp_en", ctrl_uloop.enable, 1'b0);
            check("bp_iter", iter_cnt, 16'd1);
            step();
        end
        req_ready = 1'b1;
        check("bp_addr_hs", req_addr[0], 32'h1040);
        step();
        check("bp_iter_after", iter_cnt, 16'd2);
        check("bp_run_en", ctrl_uloop.enable, 1'b1);
        uloop_step(32'h0, 32'h0, 3'd0, 6'h0, 1'b0, 1'b1);
        check("bp_done", done, 1'b1);
        check("bp_iter_fin", iter_cnt, 16'd2);
        step();

        // Done without valid after one request
        start_job(32'h2000, 32'h0);
        step();
        uloop_step(32'h0, 32'h0, 3'd0, 6'h0, 1'b0, 1'b1);
        check("dnv_done", done, 1'b1);
        check("dnv_valid", req_valid, 1'b0);
        check("dnv_iter", iter_cnt, 16'd1);
        step();
        check("dnv_idle", busy, 1'b0);

        // Address wrap, second lane alongside
        start_job(32'hFFFF_FFF0, 32'h0000_0100);
        check("wrap_base1", req_addr[1], 32'h0000_0100);
        step();
        uloop_step(32'h20, 32'h3, 3'd0, 6'h0, 1'b1, 1'b1);
        check("wrap_addr0", req_addr[0], 32'h0000_0010);
        check("wrap_addr1", req_addr[1], 32'h0000_0103);
        check("wrap_last", req_last, 1'b1);
        step();
        check("wrap_done", done, 1'b1);
        step();

        // Start ignored in RUN, then clear_i during a stalled ISSUE
        start_job(32'h3000, 32'h0);
        step();
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        check("ign_start_en", ctrl_uloop.enable, 1'b1);
        check("ign_start_clr", ctrl_uloop.clear, 1'b0);
        check("ign_start_iter", iter_cnt, 16'd1);
        req_ready = 1'b0;
        uloop_step(32'h8, 32'h0, 3'd0, 6'h0, 1'b1, 1'b0);
        check("cl_pre_valid", req_valid, 1'b1);
        check("cl_pre_addr", req_addr[0], 32'h3008);
        step();
        clear_i = 1'b1;
        #1;
        check("cl_valid", req_valid, 1'b0);
        check("cl_clear", ctrl_uloop.clear, 1'b1);
        check("cl_en", ctrl_uloop.enable, 1'b0);
        step();
        clear_i = 1'b0;
        check("cl_busy", busy, 1'b0);
        check("cl_done", done, 1'b0);
        check("cl_iter", iter_cnt, 16'd0);
        step();
        check("cl_done2", done, 1'b0);
        check("cl_valid2", req_valid, 1'b0);

        // Asynchronous reset in the middle of RUN
        req_ready = 1'b1;
        start_job(32'h4000, 32'h0);
        step();
        check("mr_en_pre", ctrl_uloop.enable, 1'b1);
        #2;
        rst_ni = 1'b0;
        #1;
        check_quiet("mr");
        #3;
        rst_ni = 1'b1;
        step();
        check("mr_idle_busy", busy, 1'b0);
        check("mr_idle_en", ctrl_uloop.enable, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
